// File: rtl/delta_counter_bank.sv
// delta_counter_bank: bank of independent up/down delta counters with
// wrap/saturate mode, sticky over/underflow flag and threshold crossing pulse.
module delta_counter_bank #(
    parameter int NumChannels = 4,
    parameter int WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic [NumChannels-1:0]       clear_i,
    input  logic [NumChannels-1:0]       en_i,
    input  logic [NumChannels-1:0]       load_i,
    input  logic [NumChannels-1:0]       down_i,
    input  logic [NumChannels-1:0]       sat_i,
    input  logic [NumChannels-1:0]       ovf_clr_i,
    input  logic [NumChannels*WIDTH-1:0] delta_i,
    input  logic [NumChannels*WIDTH-1:0] d_i,
    input  logic [NumChannels*WIDTH-1:0] thresh_i,
    output logic [NumChannels*WIDTH-1:0] q_o,
    output logic [NumChannels-1:0]       overflow_o,
    output logic [NumChannels-1:0]       thresh_o,
    output logic [NumChannels-1:0]       thresh_evt_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [WIDTH-1:0] q_q, q_d, dl, dv, th, diff;
        logic [WIDTH:0]   sum;
        logic             ovf_q, ovf_d, evt_q, evt_d;
        logic             wipe, under, hit;

        assign dl    = delta_i[c*WIDTH +: WIDTH];
        assign dv    = d_i[c*WIDTH +: WIDTH];
        assign th    = thresh_i[c*WIDTH +: WIDTH];
        assign wipe  = clr_i | clear_i[c];
        assign sum   = {1'b0, q_q} + {1'b0, dl};
        assign diff  = q_q - dl;
        assign under = dl > q_q;

        always_comb begin
            q_d   = q_q;
            ovf_d = ovf_q & ~ovf_clr_i[c];
            hit   = 1'b0;
            if (wipe) begin
                q_d   = '0;
                ovf_d = 1'b0;
            end else if (load_i[c]) begin
                q_d   = dv;
                ovf_d = 1'b0;
            end else if (en_i[c]) begin
                if (down_i[c]) begin
                    hit = under;
                    q_d = (under && sat_i[c]) ? '0 : diff;
                end else begin
                    hit = sum[WIDTH];
                    q_d = (sum[WIDTH] && sat_i[c]) ? '1 : sum[WIDTH-1:0];
                end
                // a fresh over/underflow beats a same-cycle flag clear
                if (hit) ovf_d = 1'b1;
            end
        end

        assign evt_d = !wipe && (q_q < th) && (q_d >= th);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q_q   <= '0;
                ovf_q <= 1'b0;
                evt_q <= 1'b0;
            end else begin
                q_q   <= q_d;
                ovf_q <= ovf_d;
                evt_q <= evt_d;
            end
        end

        assign q_o[c*WIDTH +: WIDTH] = q_q;
        assign overflow_o[c]         = ovf_q;
        assign thresh_evt_o[c]       = evt_q;
        assign thresh_o[c]           = q_q >= th;
    end

endmodule

// File: tb/tb_delta_counter_bank.sv
// Directed table plus random scoreboard bench for delta_counter_bank.
module tb_delta_counter_bank;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clr_i = 1'b0;
    logic [N-1:0]   clear_i = '0, en_i = '0, load_i = '0;
    logic [N-1:0]   down_i = '0, sat_i = '0, ovf_clr_i = '0;
    logic [N*W-1:0] delta_i = '0, d_i = '0, thresh_i = '0;
    logic [N*W-1:0] q_o;
    logic [N-1:0]   overflow_o, thresh_o, thresh_evt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delta_counter_bank #(.NumChannels(N), .WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .clear_i(clear_i),
        .en_i(en_i), .load_i(load_i), .down_i(down_i), .sat_i(sat_i),
        .ovf_clr_i(ovf_clr_i), .delta_i(delta_i), .d_i(d_i),
        .thresh_i(thresh_i), .q_o(q_o), .overflow_o(overflow_o),
        .thresh_o(thresh_o), .thresh_evt_o(thresh_evt_o)
    );

    typedef struct {
        int          ch;
        bit          clr, ld, en, dn, sat, oc;
        logic [15:0] delta, d, th, eq;
        bit          eovf, eevt, eth;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int ch, bit clr, bit ld, bit en, bit dn,
                                bit sat, bit oc, logic [15:0] delta,
                                logic [15:0] d, logic [15:0] th,
                                logic [15:0] eq, bit eo, bit ee, bit et);
        vec_t v;
        v.ch = ch; v.clr = clr; v.ld = ld; v.en = en; v.dn = dn;
        v.sat = sat; v.oc = oc; v.delta = delta; v.d = d; v.th = th;
        v.eq = eq; v.eovf = eo; v.eevt = ee; v.eth = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        clr_i = 0; clear_i = '0; en_i = '0; load_i = '0;
        down_i = '0; sat_i = '0; ovf_clr_i = '0;
        delta_i = '0; d_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mq[N];
        bit mo[N], me[N];
        logic [N*W-1:0] eq_all;
        logic [N-1:0] eo_all, ee_all, et_all;

        // ch0: wrap overflow, sticky, re-cross after wrap
        tbl.push_back(mk(0,0,1,0,0,0,0,16'h0000,16'hFFF0,16'h8000,16'hFFF0,0,1,1));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0020,16'h0000,16'h8000,16'h0010,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0001,16'h0000,16'h8000,16'h0011,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0001,16'h0000,16'h8000,16'h0012,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0001,16'h0000,16'h8000,16'h0013,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0001,16'h0000,16'h8000,16'h0014,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h0001,16'h0000,16'h8000,16'h0015,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,16'h8000,16'h0000,16'h8000,16'h8015,1,1,1));
        // ch1: saturating underflow, load clears flag, exact landing on max
        tbl.push_back(mk(1,0,1,0,0,1,0,16'h0000,16'h0005,16'hFFFF,16'h0005,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,1,0,16'h0009,16'h0000,16'hFFFF,16'h0000,1,0,0));
        tbl.push_back(mk(1,0,1,0,0,1,0,16'h0000,16'h0007,16'hFFFF,16'h0007,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,1,0,16'h0000,16'hFFFE,16'hFFFF,16'hFFFE,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,1,0,16'h0001,16'h0000,16'hFFFF,16'hFFFF,0,1,1));
        // ch2: threshold crossing events
        tbl.push_back(mk(2,0,1,0,0,0,0,16'h0000,16'd90,16'd100,16'd90,0,0,0));
        tbl.push_back(mk(2,0,0,1,0,0,0,16'd10,16'h0000,16'd100,16'd100,0,1,1));
        tbl.push_back(mk(2,0,0,1,0,0,0,16'd1,16'h0000,16'd100,16'd101,0,0,1));
        tbl.push_back(mk(2,0,0,1,0,0,0,16'd1,16'h0000,16'd100,16'd102,0,0,1));
        tbl.push_back(mk(2,0,0,1,1,0,0,16'd52,16'h0000,16'd100,16'd50,0,0,0));
        tbl.push_back(mk(2,0,1,0,0,0,0,16'h0000,16'd150,16'd100,16'd150,0,1,1));
        tbl.push_back(mk(2,0,0,1,0,0,0,16'd0,16'h0000,16'd100,16'd150,0,0,1));
        tbl.push_back(mk(2,0,0,0,0,0,0,16'd0,16'h0000,16'd200,16'd150,0,0,0));
        tbl.push_back(mk(2,0,0,0,0,0,0,16'd0,16'h0000,16'd100,16'd150,0,0,1));
        // ch3: set beats ovf_clr, exact landings, wrap underflow, clear
        tbl.push_back(mk(3,0,1,0,0,0,0,16'h0000,16'hFFFF,16'h0000,16'hFFFF,0,0,1));
        tbl.push_back(mk(3,0,0,1,0,0,1,16'h0002,16'h0000,16'h0000,16'h0001,1,0,1));
        tbl.push_back(mk(3,0,0,0,0,0,1,16'h0000,16'h0000,16'h0000,16'h0001,0,0,1));
        tbl.push_back(mk(3,0,0,1,0,0,0,16'hFFFE,16'h0000,16'h0000,16'hFFFF,0,0,1));
        tbl.push_back(mk(3,0,0,1,1,0,0,16'hFFFF,16'h0000,16'h0000,16'h0000,0,0,1));
        tbl.push_back(mk(3,0,0,1,1,0,0,16'h0001,16'h0000,16'h0000,16'hFFFF,1,0,1));
        tbl.push_back(mk(3,1,0,0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000,0,0,1));

        idle();
        #12;
        chk("reset", {q_o, overflow_o, thresh_evt_o},
            {{(N*W){1'b0}}, {N{1'b0}}, {N{1'b0}}});
        @(negedge clk);
        rst_ni = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            idle();
            clear_i[tbl[i].ch]   = tbl[i].clr;
            load_i[tbl[i].ch]    = tbl[i].ld;
            en_i[tbl[i].ch]      = tbl[i].en;
            down_i[tbl[i].ch]    = tbl[i].dn;
            sat_i[tbl[i].ch]     = tbl[i].sat;
            ovf_clr_i[tbl[i].ch] = tbl[i].oc;
            delta_i[tbl[i].ch*W +: W]  = tbl[i].delta;
            d_i[tbl[i].ch*W +: W]      = tbl[i].d;
            thresh_i[tbl[i].ch*W +: W] = tbl[i].th;
            tick();
            chk($sformatf("vec%0d", i),
                {q_o[tbl[i].ch*W +: W], overflow_o[tbl[i].ch],
                 thresh_evt_o[tbl[i].ch], thresh_o[tbl[i].ch]},
                {tbl[i].eq, tbl[i].eovf, tbl[i].eevt, tbl[i].eth});
        end

        // clear beats load and enable on every channel
        @(negedge clk);
        idle();
        thresh_i = '0;
        load_i = '1; d_i = {N{16'h1234}};
        tick();
        chk("load_all", q_o, {N{16'h1234}});
        @(negedge clk);
        load_i = '1; en_i = '1; clear_i = '1;
        d_i = {N{16'h5555}}; delta_i = {N{16'h0001}};
        tick();
        chk("clear_prio", {q_o, overflow_o, thresh_evt_o},
            {{(N*W){1'b0}}, {N{1'b0}}, {N{1'b0}}});

        // clr_i overrides everything
        @(negedge clk);
        idle();
        load_i = '1; d_i = {N{16'hFFFF}};
        tick();
        @(negedge clk);
        idle();
        en_i = '1; delta_i = {N{16'h0001}};
        tick();
        chk("ovf_all", {q_o, overflow_o}, {{(N*W){1'b0}}, {N{1'b1}}});
        @(negedge clk);
        clr_i = 1; load_i = '1; en_i = '1; clear_i = '1; ovf_clr_i = '1;
        down_i = '0; sat_i = '1;
        d_i = {N{16'h7777}}; delta_i = {N{16'h0003}};
        thresh_i = {N{16'h0100}};
        tick();
        chk("clr_all", {q_o, overflow_o, thresh_evt_o, thresh_o},
            {{(N*W){1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}});

        // async reset mid-count, with a pulse pending on ch0
        @(negedge clk);
        idle();
        thresh_i = {16'h0, 16'h0, 16'h0, 16'h0003};
        en_i = '1; delta_i = {N{16'h0001}};
        tick();
        tick();
        tick();
        chk("pre_rst", {q_o[W-1:0], thresh_evt_o[0]}, {16'h0003, 1'b1});
        #2;
        rst_ni = 0;
        #1;
        chk("async_rst", {q_o, overflow_o, thresh_evt_o},
            {{(N*W){1'b0}}, {N{1'b0}}, {N{1'b0}}});
        @(negedge clk);
        idle();
        rst_ni = 1;

        // random independent traffic against a reference model
        foreach (mq[c]) begin
            mq[c] = 0; mo[c] = 0; me[c] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit rclr;
            @(negedge clk);
            idle();
            rclr = ($urandom_range(0, 199) == 0);
            clr_i = rclr;
            for (int c = 0; c < N; c++) begin
                int th, dl, s, nq;
                bit no, ne, wipe;
                clear_i[c]   = ($urandom_range(0, 29) == 0);
                load_i[c]    = ($urandom_range(0, 9) == 0);
                en_i[c]      = ($urandom_range(0, 9) < 6);
                down_i[c]    = $urandom_range(0, 1);
                sat_i[c]     = $urandom_range(0, 1);
                ovf_clr_i[c] = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0: dl = 0;
                    1: dl = $urandom_range(0, 65535);
                    default: dl = $urandom_range(1, 300);
                endcase
                delta_i[c*W +: W] = dl[15:0];
                d_i[c*W +: W] = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 49) == 0)
                    thresh_i[c*W +: W] = 16'($urandom_range(0, 65535));
                th = int'(thresh_i[c*W +: W]);
                wipe = rclr || clear_i[c];
                nq = mq[c];
                no = mo[c] && !ovf_clr_i[c];
                if (wipe) begin
                    nq = 0; no = 0;
                end else if (load_i[c]) begin
                    nq = int'(d_i[c*W +: W]); no = 0;
                end else if (en_i[c]) begin
                    s = down_i[c] ? mq[c] - dl : mq[c] + dl;
                    if (s > 65535) begin
                        no = 1; nq = sat_i[c] ? 65535 : s - 65536;
                    end else if (s < 0) begin
                        no = 1; nq = sat_i[c] ? 0 : s + 65536;
                    end else begin
                        nq = s;
                    end
                end
                ne = !wipe && (mq[c] < th) && (nq >= th);
                mq[c] = nq; mo[c] = no; me[c] = ne;
                eq_all[c*W +: W] = nq[15:0];
                eo_all[c] = no;
                ee_all[c] = ne;
                et_all[c] = (nq >= th);
            end
            tick();
            chk($sformatf("rand%0d", cyc),
                {q_o, overflow_o, thresh_evt_o, thresh_o},
                {eq_all, eo_all, ee_all, et_all});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delta_counter_bank.md
Name: delta_counter_bank

Overview:
- Bank of NumChannels independent up/down counters with variable delta.
- Each channel has a runtime-selectable wrap or saturate mode, a sticky over/underflow flag, and a threshold comparator with a registered crossing-event pulse.
- Sits beside event/perf-counter and timer logic.
- Shares one clock and reset across all channels, so a subsystem instantiates one bank instead of N scalar counters.

Parameters:
- NumChannels, 4, number of independent counter channels (>=1).
- WIDTH, 16, counter width per channel (>=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear of all registers in all channels.
- clear_i  in  NumChannels  per-channel synchronous clear (counter, flag, event).
- en_i  in  NumChannels  per-channel count enable.
- load_i  in  NumChannels  per-channel load of d_i.
- down_i  in  NumChannels  1 = subtract delta, 0 = add.
- sat_i  in  NumChannels  1 = saturate at bounds, 0 = wrap modulo 2^WIDTH.
- ovf_clr_i  in  NumChannels  clear sticky overflow flag only.
- delta_i  in  NumChannels*WIDTH  per-channel delta; channel c uses bits [c*WIDTH +: WIDTH].
- d_i  in  NumChannels*WIDTH  per-channel load value, same packing.
- thresh_i  in  NumChannels*WIDTH  per-channel threshold, same packing.
- q_o  out  NumChannels*WIDTH  registered counter values, same packing.
- overflow_o  out  NumChannels  sticky over/underflow flag (registered).
- thresh_o  out  NumChannels  combinational level: q_o[c] >= thresh_i[c], unsigned.
- thresh_evt_o  out  NumChannels  registered one-cycle pulse on upward threshold crossing.

Behaviour:
- Reset (rst_ni low, async): all q = 0, overflow = 0, thresh_evt = 0.
- clr_i has the same effect synchronously and overrides every other input.
- Per-channel priority for the next state: clr_i > clear_i[c] > load_i[c] > en_i[c].
- Idle: registers hold.
- Latency: one cycle. q_o reflects an update on the clock edge after inputs are sampled.
- clear_i[c]: q = 0, overflow = 0, thresh_evt = 0.
- load_i[c]: q = d. overflow is cleared. thresh_evt follows the crossing rule below.
- en_i[c] up: sum = {1'b0,q} + {1'b0,delta}, WIDTH+1 bits.
  - Overflow if sum[WIDTH] = 1.
  - Wrap: q = sum[WIDTH-1:0].
  - Saturate: q = 2^WIDTH-1 on overflow, else sum.
- en_i[c] down:
  - Underflow if delta > q.
  - Wrap: q = q - delta mod 2^WIDTH.
  - Saturate: q = 0 on underflow, else q - delta.
- delta = 0 with en: q unchanged, no overflow.
- Exact landing on max (up) or 0 (down) is not an overflow.
- Sticky flag:
  - Set when an enabled update over/underflows.
  - Cleared by clear_i, load_i or ovf_clr_i.
  - If a set and ovf_clr_i[c] occur in the same cycle, set wins (flag = 1).
  - Saturated channels still flag.
  - Once set, the flag holds regardless of further enabled updates.
- Threshold compare: unsigned, using the current thresh_i on both sides.
  - thresh_evt_d = !(q_q >= thresh) && (q_d >= thresh).
  - The pulse is visible in the same cycle q_o first shows the value >= thresh.
  - It fires on a count, a wrap-free jump, or a load that crosses.
  - It never fires on clear/clr_i, on a down-crossing, or while q stays >= thresh.
  - A wrap from high to low followed by a later re-crossing fires again.
  - A thresh_i change alone never produces a pulse.
  - thresh = 0: no event is possible, since q >= 0 always holds and thresh_o = 1.
- Channels are fully independent: no shared arithmetic, no cross-channel priority.
- Reset asserted mid-operation: outputs go to reset values immediately (async). No pending pulse survives reset.

Test Plan:
- WIDTH=16, ch0 sat=0, q=0xFFF0, up delta 0x20 -> q=0x0010, overflow_o[0]=1 next cycle, stays 1 over 5 more enabled increments without overflow.
- ch1 sat=1, q=5, down delta 9 -> q=0, overflow_o[1]=1; then load d=7 -> q=7, overflow_o[1]=0. ch1 sat=1, q=0xFFFE, up delta 1 -> q=0xFFFF, overflow_o[1]=0.
- ch2 thresh=100, q=90, up delta 10 -> q=100, thresh_evt_o[2]=1 one cycle; repeated +1 -> no further pulse; down to 50 then load 150 -> one pulse.
- ch3: ovf_clr_i and a new overflow in the same cycle -> overflow_o[3]=1; ovf_clr_i alone next cycle -> 0, q unchanged.
- All channels: load, en and clear_i asserted together -> q=0. clr_i with every other input active -> all outputs 0. Async rst_ni pulse mid-count -> q_o=0 before the next edge.
- Random independent per-channel traffic (10k cycles) against a scoreboard model -> no cross-channel interference, every output matches.
